// File: rtl/axi4_lite_regfile_if.sv
`default_nettype none
// ============================================================================
// Module      : axi4_lite_regfile_if
// Description : AXI4-Lite bus bundle for axi4_lite_regfile. Carries the five
//               channels (AW, W, B, AR, R). The master modport drives
//               requests and the slave modport drives READY/response signals.
// Parameters  : ADDR_W - address width, DATA_W - data width (32 or 64)
// Revision    : 1.0 - initial release
// ============================================================================
interface axi4_lite_regfile_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  AWVALID;
    logic                  AWREADY;
    logic [ADDR_W-1:0]     AWADDR;
    logic [2:0]            AWPROT;
    logic                  WVALID;
    logic                  WREADY;
    logic [DATA_W-1:0]     WDATA;
    logic [DATA_W/8-1:0]   WSTRB;
    logic                  BVALID;
    logic                  BREADY;
    logic [1:0]            BRESP;
    logic                  ARVALID;
    logic                  ARREADY;
    logic [ADDR_W-1:0]     ARADDR;
    logic [2:0]            ARPROT;
    logic                  RVALID;
    logic                  RREADY;
    logic [DATA_W-1:0]     RDATA;
    logic [1:0]            RRESP;

    modport master (
        output AWVALID, AWADDR, AWPROT, WVALID, WDATA, WSTRB, BREADY,
               ARVALID, ARADDR, ARPROT, RREADY,
        input  AWREADY, WREADY, BVALID, BRESP, ARREADY, RVALID, RDATA, RRESP
    );

    modport slave (
        input  AWVALID, AWADDR, AWPROT, WVALID, WDATA, WSTRB, BREADY,
               ARVALID, ARADDR, ARPROT, RREADY,
        output AWREADY, WREADY, BVALID, BRESP, ARREADY, RVALID, RDATA, RRESP
    );
endinterface
`default_nettype wire

// File: rtl/axi4_lite_regfile.sv
`default_nettype none
// ============================================================================
// Module      : axi4_lite_regfile
// Description : AXI4-Lite slave register file of REG_N registers, DATA_W bits
//               each, with byte-strobed writes, a one-cycle write strobe per
//               register and a flat view of all register contents.
// Ports       : ACLK        - clock, rising edge
//               ARESETn     - synchronous active-low reset
//               s_axi       - AXI4-Lite slave bus (axi4_lite_regfile_if.slave)
//               regs_out    - register k at [k*DATA_W +: DATA_W]
//               wr_pulse    - one-cycle strobe per written register
// Config      : AXI4_LITE_REGFILE_SLVERR_EN - when defined, out-of-range
//               accesses answer SLVERR (2'b10) instead of OKAY.
// Revision    : 1.0 - initial release
// ============================================================================
module axi4_lite_regfile #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int REG_N  = 16
) (
    input  wire logic               ACLK,
    input  wire logic               ARESETn,
    axi4_lite_regfile_if.slave      s_axi,
    output logic [REG_N*DATA_W-1:0] regs_out,
    output logic [REG_N-1:0]        wr_pulse
);
    localparam int STRB_W = DATA_W / 8;
    localparam int OFS    = $clog2(STRB_W);
    localparam int IDX_W  = $clog2(REG_N);
    localparam int HI     = OFS + IDX_W;

    localparam logic [1:0] RESP_OKAY = 2'b00;
`ifdef AXI4_LITE_REGFILE_SLVERR_EN
    localparam logic [1:0] RESP_OOR  = 2'b10;
`else
    localparam logic [1:0] RESP_OOR  = 2'b00;
`endif

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_EXEC = 2'd1,
        W_RESP = 2'd2
    } wstate_e;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rstate_e;

    wstate_e             wstate_q, wstate_d;
    logic                aw_got_q, aw_got_d;
    logic                w_got_q, w_got_d;
    logic [ADDR_W-1:0]   awaddr_q, awaddr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [STRB_W-1:0]   wstrb_q, wstrb_d;
    logic                awready_q, awready_d;
    logic                wready_q, wready_d;
    logic                bvalid_q, bvalid_d;
    logic [1:0]          bresp_q, bresp_d;
    logic [REG_N-1:0]    wr_pulse_q, wr_pulse_d;
    logic [DATA_W-1:0]   regs_q [REG_N];
    logic [DATA_W-1:0]   regs_d [REG_N];

    rstate_e             rstate_q, rstate_d;
    logic                arready_q, arready_d;
    logic                rvalid_q, rvalid_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [1:0]          rresp_q, rresp_d;

    // Once AW is captured the held address is the one in force; before that
    // the live bus address is the one that may be captured this cycle. This
    // lets the write strobe be registered on the edge entering W_EXEC.
    logic [ADDR_W-1:0]   w_awaddr_sel;
    logic [IDX_W-1:0]    w_aw_idx;
    logic                w_aw_oor;
    logic [IDX_W-1:0]    w_ar_idx;
    logic                w_ar_oor;
    logic                w_unused_prot;

    assign w_awaddr_sel  = aw_got_q ? awaddr_q : s_axi.AWADDR;
    assign w_aw_idx      = w_awaddr_sel[OFS +: IDX_W];
    assign w_aw_oor      = |(w_awaddr_sel >> HI);
    assign w_ar_idx      = s_axi.ARADDR[OFS +: IDX_W];
    assign w_ar_oor      = |(s_axi.ARADDR >> HI);
    assign w_unused_prot = ^{s_axi.AWPROT, s_axi.ARPROT};

    // Write channel next-state
    always_comb begin
        wstate_d   = wstate_q;
        aw_got_d   = aw_got_q;
        w_got_d    = w_got_q;
        awaddr_d   = awaddr_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        awready_d  = awready_q;
        wready_d   = wready_q;
        bvalid_d   = bvalid_q;
        bresp_d    = bresp_q;
        wr_pulse_d = '0;
        regs_d     = regs_q;

        case (wstate_q)
            W_IDLE: begin
                if (s_axi.AWVALID && awready_q) begin
                    aw_got_d = 1'b1;
                    awaddr_d = s_axi.AWADDR;
                end
                if (s_axi.WVALID && wready_q) begin
                    w_got_d = 1'b1;
                    wdata_d = s_axi.WDATA;
                    wstrb_d = s_axi.WSTRB;
                end
                awready_d = !aw_got_d;
                wready_d  = !w_got_d;
                if (aw_got_d && w_got_d) begin
                    wstate_d = W_EXEC;
                    if (!w_aw_oor) begin
                        wr_pulse_d[w_aw_idx] = 1'b1;
                    end
                end
            end
            W_EXEC: begin
                if (!w_aw_oor) begin
                    for (int i = 0; i < STRB_W; i++) begin
                        if (wstrb_q[i]) begin
                            regs_d[w_aw_idx][8*i +: 8] = wdata_q[8*i +: 8];
                        end
                    end
                end
                bvalid_d = 1'b1;
                bresp_d  = w_aw_oor ? RESP_OOR : RESP_OKAY;
                wstate_d = W_RESP;
            end
            W_RESP: begin
                if (s_axi.BREADY) begin
                    bvalid_d  = 1'b0;
                    aw_got_d  = 1'b0;
                    w_got_d   = 1'b0;
                    awready_d = 1'b1;
                    wready_d  = 1'b1;
                    wstate_d  = W_IDLE;
                end
            end
            default: begin
                wstate_d = W_IDLE;
            end
        endcase
    end

    // Read channel next-state; RDATA samples regs_q, so a read accepted on
    // the W_EXEC edge returns the value from before that write.
    always_comb begin
        rstate_d  = rstate_q;
        arready_d = arready_q;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;

        case (rstate_q)
            R_IDLE: begin
                arready_d = 1'b1;
                if (s_axi.ARVALID && arready_q) begin
                    arready_d = 1'b0;
                    rvalid_d  = 1'b1;
                    rstate_d  = R_DATA;
                    if (w_ar_oor) begin
                        rdata_d = '0;
                        rresp_d = RESP_OOR;
                    end else begin
                        rdata_d = regs_q[w_ar_idx];
                        rresp_d = RESP_OKAY;
                    end
                end
            end
            R_DATA: begin
                if (s_axi.RREADY) begin
                    rvalid_d  = 1'b0;
                    arready_d = 1'b1;
                    rstate_d  = R_IDLE;
                end
            end
            default: begin
                rstate_d = R_IDLE;
            end
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            wstate_q   <= W_IDLE;
            aw_got_q   <= 1'b0;
            w_got_q    <= 1'b0;
            awaddr_q   <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            bvalid_q   <= 1'b0;
            bresp_q    <= 2'b00;
            wr_pulse_q <= '0;
            for (int k = 0; k < REG_N; k++) begin
                regs_q[k] <= '0;
            end
            rstate_q   <= R_IDLE;
            arready_q  <= 1'b0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            rresp_q    <= 2'b00;
        end else begin
            wstate_q   <= wstate_d;
            aw_got_q   <= aw_got_d;
            w_got_q    <= w_got_d;
            awaddr_q   <= awaddr_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            awready_q  <= awready_d;
            wready_q   <= wready_d;
            bvalid_q   <= bvalid_d;
            bresp_q    <= bresp_d;
            wr_pulse_q <= wr_pulse_d;
            regs_q     <= regs_d;
            rstate_q   <= rstate_d;
            arready_q  <= arready_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
        end
    end

    assign s_axi.AWREADY = awready_q;
    assign s_axi.WREADY  = wready_q;
    assign s_axi.BVALID  = bvalid_q;
    assign s_axi.BRESP   = bresp_q;
    assign s_axi.ARREADY = arready_q;
    assign s_axi.RVALID  = rvalid_q;
    assign s_axi.RDATA   = rdata_q;
    assign s_axi.RRESP   = rresp_q;
    assign wr_pulse      = wr_pulse_q;

    generate
        for (genvar k = 0; k < REG_N; k++) begin : g_regs_out
            assign regs_out[k*DATA_W +: DATA_W] = regs_q[k];
        end
    endgenerate
endmodule
`default_nettype wire

// File: tb/tb_axi4_lite_regfile.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi4_lite_regfile
// Description : Directed self-checking bench for axi4_lite_regfile with
//               DATA_W=32, REG_N=16. A register model plus B/R response
//               queues supply every expected value.
// Config      : AXI4_LITE_REGFILE_SLVERR_EN selects the out-of-range response.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi4_lite_regfile;
    logic         ACLK = 1'b0;
    logic         ARESETn;
    logic [511:0] regs_out;
    logic [15:0]  wr_pulse;

    always #5 ACLK = ~ACLK;

    axi4_lite_regfile_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    axi4_lite_regfile #(.ADDR_W(32), .DATA_W(32), .REG_N(16)) dut (
        .ACLK     (ACLK),
        .ARESETn  (ARESETn),
        .s_axi    (bus),
        .regs_out (regs_out),
        .wr_pulse (wr_pulse)
    );

`ifdef AXI4_LITE_REGFILE_SLVERR_EN
    localparam logic [1:0] OOR_RESP = 2'b10;
`else
    localparam logic [1:0] OOR_RESP = 2'b00;
`endif

    int          n_cmp = 0;
    int          n_mis = 0;
    logic [31:0] model [16];
    logic [1:0]  bq [$];
    logic [33:0] rq [$];

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [511:0] packed_model();
        logic [511:0] v;
        for (int k = 0; k < 16; k++) v[k*32 +: 32] = model[k];
        return v;
    endfunction

    task automatic cyc();
        @(posedge ACLK);
        @(negedge ACLK);
    endtask

    // order: 0 = AW and W together, 1 = AW one cycle first, 2 = W first
    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input int order, input string tag);
        logic        aw_done, w_done, hs_aw, hs_w, in_rng;
        logic [15:0] exp_pulse;
        logic [1:0]  exp_resp;
        aw_done   = 1'b0;
        w_done    = 1'b0;
        in_rng    = (addr[31:6] == 26'd0);
        exp_pulse = in_rng ? (16'h1 << addr[5:2]) : 16'h0;
        bq.push_back(in_rng ? 2'b00 : OOR_RESP);
        if (order != 2) begin bus.AWVALID = 1'b1; bus.AWADDR = addr; end
        if (order != 1) begin bus.WVALID = 1'b1; bus.WDATA = data; bus.WSTRB = strb; end
        for (int c = 0; c < 20 && !(aw_done && w_done); c++) begin
            hs_aw = bus.AWVALID && bus.AWREADY;
            hs_w  = bus.WVALID && bus.WREADY;
            cyc();
            if (hs_aw) begin bus.AWVALID = 1'b0; aw_done = 1'b1; end
            if (hs_w)  begin bus.WVALID = 1'b0; w_done = 1'b1; end
            if (order == 1 && aw_done && !w_done && !bus.WVALID) begin
                check({tag, "_awready_low"}, bus.AWREADY, 1'b0);
                bus.WVALID = 1'b1; bus.WDATA = data; bus.WSTRB = strb;
            end
            if (order == 2 && w_done && !aw_done && !bus.AWVALID) begin
                check({tag, "_wready_low"}, bus.WREADY, 1'b0);
                bus.AWVALID = 1'b1; bus.AWADDR = addr;
            end
        end
        check({tag, "_handshake"}, {aw_done, w_done}, 2'b11);
        check({tag, "_pulse"}, wr_pulse, exp_pulse);
        check({tag, "_bvalid_early"}, bus.BVALID, 1'b0);
        if (in_rng) begin
            for (int i = 0; i < 4; i++)
                if (strb[i]) model[addr[5:2]][8*i +: 8] = data[8*i +: 8];
        end
        cyc();
        check({tag, "_pulse_clear"}, wr_pulse, 16'h0);
        check({tag, "_bvalid"}, bus.BVALID, 1'b1);
        check({tag, "_regs"}, regs_out, packed_model());
        exp_resp = (bq.size() > 0) ? bq.pop_front() : 2'bxx;
        check({tag, "_bresp"}, bus.BRESP, exp_resp);
        bus.BREADY = 1'b1;
        cyc();
        bus.BREADY = 1'b0;
        check({tag, "_bvalid_drop"}, bus.BVALID, 1'b0);
        check({tag, "_awready_back"}, bus.AWREADY, 1'b1);
    endtask

    task automatic axi_read(input logic [31:0] addr, input int hold, input string tag);
        logic        in_rng;
        logic [33:0] exp;
        in_rng = (addr[31:6] == 26'd0);
        rq.push_back(in_rng ? {2'b00, model[addr[5:2]]} : {OOR_RESP, 32'h0});
        check({tag, "_arready"}, bus.ARREADY, 1'b1);
        bus.ARVALID = 1'b1;
        bus.ARADDR  = addr;
        cyc();
        bus.ARVALID = 1'b0;
        check({tag, "_rvalid"}, bus.RVALID, 1'b1);
        exp = (rq.size() > 0) ? rq.pop_front() : 34'bx;
        check({tag, "_rdata"}, bus.RDATA, exp[31:0]);
        check({tag, "_rresp"}, bus.RRESP, exp[33:32]);
        for (int i = 0; i < hold; i++) begin
            cyc();
            check({tag, "_hold_rvalid"}, bus.RVALID, 1'b1);
            check({tag, "_hold_rdata"}, bus.RDATA, exp[31:0]);
            check({tag, "_hold_rresp"}, bus.RRESP, exp[33:32]);
        end
        bus.RREADY = 1'b1;
        cyc();
        bus.RREADY = 1'b0;
        check({tag, "_rvalid_drop"}, bus.RVALID, 1'b0);
        check({tag, "_arready_back"}, bus.ARREADY, 1'b1);
    endtask

    initial begin
        logic [1:0]  b_exp;
        logic [33:0] r_exp;
        ARESETn     = 1'b0;
        bus.AWVALID = 1'b0; bus.AWADDR = '0; bus.AWPROT = 3'd0;
        bus.WVALID  = 1'b0; bus.WDATA  = '0; bus.WSTRB  = '0;
        bus.BREADY  = 1'b0;
        bus.ARVALID = 1'b0; bus.ARADDR = '0; bus.ARPROT = 3'd0;
        bus.RREADY  = 1'b0;
        for (int k = 0; k < 16; k++) model[k] = 32'h0;

        // Reset state
        repeat (2) @(negedge ACLK);
        check("rst_awready", bus.AWREADY, 1'b0);
        check("rst_wready", bus.WREADY, 1'b0);
        check("rst_arready", bus.ARREADY, 1'b0);
        check("rst_bvalid", bus.BVALID, 1'b0);
        check("rst_rvalid", bus.RVALID, 1'b0);
        check("rst_regs", regs_out, 512'h0);
        check("rst_pulse", wr_pulse, 16'h0);
        ARESETn = 1'b1;
        cyc();
        check("rel_awready", bus.AWREADY, 1'b1);
        check("rel_wready", bus.WREADY, 1'b1);
        check("rel_arready", bus.ARREADY, 1'b1);

        // AW one cycle before W
        axi_write(32'h08, 32'hDEADBEEF, 4'hF, 1, "aw_first");
        check("reg2_value", regs_out[2*32 +: 32], 32'hDEADBEEF);
        // W before AW, partial strobes
        axi_write(32'h04, 32'hFFFFFFFF, 4'hF, 0, "fill_reg1");
        axi_write(32'h04, 32'h11223344, 4'b0101, 2, "w_first");
        check("reg1_merge", regs_out[1*32 +: 32], 32'hFF22FF44);
        // All-zero strobe: pulse and OKAY, no change
        axi_write(32'h04, 32'h00000000, 4'h0, 0, "zero_strb");
        check("reg1_kept", regs_out[1*32 +: 32], 32'hFF22FF44);
        // Top register, upper lanes only
        axi_write(32'h3C, 32'hCAFEF00D, 4'b1100, 1, "top_reg");

        // Read with RREADY held low five cycles
        axi_read(32'h08, 5, "rd_hold");
        // Low address bits ignored
        axi_read(32'h07, 0, "rd_lowbits");
        axi_read(32'h3C, 0, "rd_top");

        // Read accepted on the W_EXEC edge of a write to the same register
        bus.AWVALID = 1'b1; bus.AWADDR = 32'h08;
        bus.WVALID  = 1'b1; bus.WDATA  = 32'h0; bus.WSTRB = 4'hF;
        bq.push_back(2'b00);
        cyc();
        bus.AWVALID = 1'b0; bus.WVALID = 1'b0;
        check("race_pulse", wr_pulse, 16'h0004);
        rq.push_back({2'b00, model[2]});
        bus.ARVALID = 1'b1; bus.ARADDR = 32'h08;
        cyc();
        bus.ARVALID = 1'b0;
        model[2] = 32'h0;
        r_exp = (rq.size() > 0) ? rq.pop_front() : 34'bx;
        b_exp = (bq.size() > 0) ? bq.pop_front() : 2'bxx;
        check("race_rvalid", bus.RVALID, 1'b1);
        check("race_rdata", bus.RDATA, r_exp[31:0]);
        check("race_rresp", bus.RRESP, r_exp[33:32]);
        check("race_bvalid", bus.BVALID, 1'b1);
        check("race_bresp", bus.BRESP, b_exp);
        check("race_regs", regs_out, packed_model());
        bus.BREADY = 1'b1; bus.RREADY = 1'b1;
        cyc();
        bus.BREADY = 1'b0; bus.RREADY = 1'b0;
        check("race_bdrop", bus.BVALID, 1'b0);
        check("race_rdrop", bus.RVALID, 1'b0);
        axi_read(32'h08, 0, "rd_after_race");

        // Out-of-range accesses
        axi_write(32'h40, 32'hA5A5A5A5, 4'hF, 0, "oor_wr");
        axi_read(32'h40, 1, "oor_rd");

        // Reset while BVALID is pending
        bus.AWVALID = 1'b1; bus.AWADDR = 32'h0C;
        bus.WVALID  = 1'b1; bus.WDATA  = 32'h12345678; bus.WSTRB = 4'hF;
        cyc();
        bus.AWVALID = 1'b0; bus.WVALID = 1'b0;
        cyc();
        check("mid_bvalid", bus.BVALID, 1'b1);
        ARESETn = 1'b0;
        cyc();
        for (int k = 0; k < 16; k++) model[k] = 32'h0;
        check("mid_rst_bvalid", bus.BVALID, 1'b0);
        check("mid_rst_awready", bus.AWREADY, 1'b0);
        check("mid_rst_arready", bus.ARREADY, 1'b0);
        check("mid_rst_regs", regs_out, packed_model());
        ARESETn = 1'b1;
        cyc();
        check("mid_rel_awready", bus.AWREADY, 1'b1);
        bus.BREADY = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            check("mid_no_late_b", bus.BVALID, 1'b0);
        end
        bus.BREADY = 1'b0;

        // Normal operation after reset
        axi_write(32'h3C, 32'hCAFEF00D, 4'b1100, 1, "post_rst");
        axi_read(32'h3C, 0, "post_rst_rd");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
`default_nettype wire

// File: doc/axi4_lite_regfile.md
AXI4_LITE_REGFILE -- requirements
Module: axi4_lite_regfile

Interface
REQ-001 SHALL have parameter ADDR_W, default 32: AXI address width.
REQ-002 SHALL have parameter DATA_W, default 32: data width, 32 or 64 only.
REQ-003 SHALL have parameter REG_N, default 16: register count, power of two, 2..256.
REQ-004 SHALL have ports:
  ACLK  in  1  clock, all logic on rising edge;
  ARESETn  in  1  synchronous active-low reset;
  AWVALID/AWREADY  in/out  1 each;  AWADDR  in  ADDR_W;  AWPROT  in  3, ignored;
  WVALID/WREADY  in/out  1 each;  WDATA  in  DATA_W;  WSTRB  in  DATA_W/8;
  BVALID/BREADY  out/in  1 each;  BRESP  out  2;
  ARVALID/ARREADY  in/out  1 each;  ARADDR  in  ADDR_W;  ARPROT  in  3, ignored;
  RVALID/RREADY  out/in  1 each;  RDATA  out  DATA_W;  RRESP  out  2;
  regs_out  out  REG_N*DATA_W  register contents, register k at bits [k*DATA_W +: DATA_W];
  wr_pulse  out  REG_N  one-cycle strobe per register write.

Function
REQ-005 SHALL decode index = ADDR[OFS +: log2(REG_N)], with OFS = log2(DATA_W/8); low OFS bits ignored.
REQ-006 SHALL treat an address as out-of-range when any bit at or above OFS+log2(REG_N) is non-zero.
REQ-007 SHALL run the write FSM with states W_IDLE, W_EXEC, W_RESP.
REQ-008 W_IDLE: AWREADY=1 until AW is captured; WREADY=1 until W is captured.
REQ-009 W_IDLE: AW and W SHALL be accepted in either order or in the same cycle.
REQ-010 W_IDLE: once both are captured, the FSM SHALL move to W_EXEC on the next edge.
REQ-011 W_EXEC (one cycle): each byte lane i with WSTRB[i]=1 SHALL be updated; lanes with WSTRB[i]=0 SHALL be unchanged.
REQ-012 W_EXEC: wr_pulse[index] SHALL be 1 for this cycle only; the in-range update SHALL be visible on regs_out at the next edge.
REQ-013 W_EXEC -> W_RESP; BVALID=1 with BRESP held stable until BREADY=1; then -> W_IDLE.
REQ-014 W_IDLE, W_EXEC, W_RESP: AWREADY=WREADY=0 outside the W_IDLE capture window; no write outstanding beyond one.
REQ-015 SHALL run the read FSM with states R_IDLE (ARREADY=1) and R_DATA (ARREADY=0).
REQ-016 R_IDLE: on the AR handshake, RDATA SHALL be registered from the register value at that edge; -> R_DATA.
REQ-017 R_DATA: RVALID=1; RDATA and RRESP SHALL stay stable until RREADY=1; then -> R_IDLE.
REQ-018 Read latency SHALL be 1 cycle from AR handshake to RVALID.
REQ-019 Read and write FSMs SHALL be independent.
REQ-020 A read of register k accepted in the same cycle as the W_EXEC update of k SHALL return the pre-write value.
REQ-021 An all-zero WSTRB SHALL change no bits, SHALL still pulse wr_pulse and SHALL still respond OKAY.
REQ-022 READY outputs SHALL NOT depend combinationally on any VALID input.

Reset
REQ-023 When ARESETn=0 at a rising edge, all registers, BVALID, RVALID, wr_pulse, BRESP, RRESP and RDATA SHALL clear to 0.
REQ-024 During reset, AWREADY, WREADY and ARREADY SHALL be 0; both FSMs SHALL enter their idle states.
REQ-025 Reset mid-transaction SHALL drop all captured AW/W/AR state; the response is never issued; first READY=1 is the cycle after release.

Configuration
REQ-026 Macro AXI4_LITE_REGFILE_SLVERR_EN defined: an out-of-range write SHALL modify nothing, pulse nothing and return BRESP=2'b10.
REQ-027 Macro AXI4_LITE_REGFILE_SLVERR_EN defined: an out-of-range read SHALL return RDATA=0 and RRESP=2'b10.
REQ-028 Macro AXI4_LITE_REGFILE_SLVERR_EN undefined: out-of-range accesses SHALL be ignored as above, but BRESP=RRESP=2'b00 and RDATA=0.

Verification (DATA_W=32, REG_N=16)
REQ-029 SHALL cover: AW 0x08 one cycle before W 0xDEADBEEF, WSTRB 4'hF -> wr_pulse[2] once, regs_out reg2=0xDEADBEEF, BVALID with BRESP=0.
REQ-030 SHALL cover: W before AW to 0x04, WSTRB 4'b0101, data 0x11223344 over 0xFFFFFFFF -> reg1=0xFF22FF44.
REQ-031 SHALL cover: AR 0x08, RREADY held 0 for 5 cycles -> RVALID at +1, RDATA=0xDEADBEEF stable all 5 cycles, RRESP=0.
REQ-032 SHALL cover: AR 0x08 in the W_EXEC cycle of a write of 0x0 -> RDATA=0xDEADBEEF; a subsequent read returns 0.
REQ-033 SHALL cover: write to 0x40 and read 0x40 -> no register change; BRESP/RRESP=2'b10 with the macro, 2'b00 without; RDATA=0.
REQ-034 SHALL cover: ARESETn=0 for one cycle while BVALID=1 -> BVALID=0, all regs 0, no late B response, AWREADY=1 the cycle after release.
